instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Streaming RV32I instruction assembler, the inverse of the CPU's opcode decode path. It accepts instruction descriptions (class, register indices, funct3, immediate) over a valid/ready stream and packs each into a 32-bit machine word. It tags each word with an incrementing instruction-memory address. It sits between the host/UART program loader and the instruction-memory write port, so programs can be built on-chip without a software assembler.

## Interface
- BASE_ADDR, 32'h0000_0000: address of the first emitted word after reset or `start`.
- ADDR_WIDTH, 32: width of `out_addr`.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  pulse: flush pipeline, reload address, clear count and error.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  descriptor accepted when `in_valid & in_ready`.
- kind  input  4  class: 0 LW, 1 SW, 2 R-type, 3 AUIPC, 4 LUI, 5 BRANCH, 6 I-ALU, 7 JAL, 8–15 illegal.
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  funct3 field.
- funct7_b5  input  1  bit 30 for SUB/SRA/SRAI.
- imm  input  32  signed immediate (byte offset for branches and jumps).
- out_valid  output  1  encoded word valid.
- out_ready  input  1  sink accepts word.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_WIDTH  byte address for `out_instr`.
- instr_count  output  16  words emitted, saturating.
- error  output  1  sticky fault flag.

## Operation
- Two register stages: S1 captures the descriptor; S2 holds the encoded word and address.
- Per-stage flow: `ready_k = !valid_k | ready_{k+1}`. `in_ready = ready_1 & !start`.
- Opcodes: LW 0000011, SW 0100011, R 0110011, AUIPC 0010111, LUI 0110111, BRANCH 1100011, I-ALU 0010011, JAL 1101111.
- I format (LW, I-ALU): `{imm[11:0], rs1, funct3, rd, op}`.
  - I-ALU with funct3=101: bits[31:25] = `{0, funct7_b5, 00000}`.
  - I-ALU with funct3=001: bits[31:25] = 0.
  - Both shift cases use `imm[4:0]` as shamt.
- S format: `{imm[11:5], rs2, rs1, funct3, imm[4:0], op}`.
- R format: `{0, funct7_b5, 00000, rs2, rs1, funct3, rd, op}`.
- U format: `{imm[31:12], rd, op}`. `funct3`, `rs1` and `rs2` are ignored.
- B format: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}`.
- J format: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, op}`.
- Immediate bits outside each field are discarded (truncation).
- Illegal kind: word is 32'h0000_0013 (NOP), `error` is set.
- Address:
  - `out_addr` shows the current address register while `out_valid`.
  - Register += 4 on each output handshake; wraps modulo 2^ADDR_WIDTH.
- `instr_count` += 1 per output handshake; holds at 16'hFFFF.
- `error` is sticky; cleared only by reset or `start`.

## Timing
- Reset (reset=0 at a clock edge): S1/S2 invalid, `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `instr_count`=0, `error`=0. `in_ready`=0 during reset, 1 on the first cycle after.
- Latency: descriptor accepted at edge N → `out_valid`=1 after edge N+1.
- Throughput: one word per cycle with `out_ready` held high.
- Backpressure:
  - `out_ready`=0 holds S2 stable: `out_instr` and `out_addr` are unchanged while `out_valid & !out_ready`.
  - S1 fills next, then `in_ready` falls. No descriptor is dropped or duplicated.
- `start` at an edge:
  - S1/S2 are invalidated; in-flight words are discarded without counting.
  - Address ← BASE_ADDR; count and error are cleared.
  - A simultaneous input handshake cannot occur (`in_ready`=0).
  - A simultaneous output handshake is ignored.
- Reset mid-stream has the same effect as `start`, plus all outputs take their reset values.
- Address wrap example: ADDR_WIDTH=8 at 8'hFC → next address 8'h00, no flag.

## Configuration
- `ENCODER_RANGE_CHECK_EN` defined: a failed check sets `error`; the truncated word is still emitted. Checks:
  - I/S: imm within [-2048, 2047].
  - I-ALU shifts: imm within [0, 31].
  - B: imm within [-4096, 4094] and imm[0]=0.
  - J: imm within [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
- Undefined: no range logic; `error` reflects illegal kinds only.

## Test plan
- After reset, `kind`=6, rd=1, rs1=0, funct3=0, imm=5 → `out_instr`=32'h00500093, `out_addr`=BASE_ADDR, two cycles after acceptance.
- Back-to-back R (rd=3, rs1=1, rs2=2, funct7_b5=1 → 32'h402081B3) then SW (rs1=2, rs2=3, imm=8, funct3=010 → 32'h00312423):
  - addresses BASE, BASE+4; `instr_count`=2.
- BRANCH rs1=1, rs2=2, funct3=0, imm=-4 → 32'hFE208EE3; JAL rd=1, imm=2048 → 32'h001000EF.
- `out_ready` low for 5 cycles with 4 descriptors offered:
  - exactly 2 accepted; `out_instr` stable; all 4 emitted in order after release.
- `kind`=9 → NOP 32'h00000013 and `error`=1 held; `start` pulse → `error`=0, address BASE, count 0.
- With `ENCODER_RANGE_CHECK_EN`: I-ALU imm=4096 → `error`=1, word has imm field 12'h000. Without the macro: `error` stays 0.

Source files
------------

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - streaming RV32I instruction assembler with address tagging
//
// Packs instruction descriptors into 32-bit RV32I machine words through a
// two-stage valid/ready pipeline (S1 = descriptor, S2 = encoded word + address).
//
// Ports:
//   clock, reset (sync, active-low), start (flush/reload pulse)
//   in_valid/in_ready + kind, rd, rs1, rs2, funct3, funct7_b5, imm : descriptor stream
//   out_valid/out_ready + out_instr, out_addr                     : word stream
//   instr_count (saturating words emitted), error (sticky fault)
//
// Optional: define ENCODER_RANGE_CHECK_EN to flag immediates that do not fit
// their instruction format (the truncated word is still emitted).

module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            kind,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic                  funct7_b5,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [15:0]           instr_count,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // S1: captured descriptor
  logic        s1_valid;
  logic [3:0]  s1_kind;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_funct3;
  logic        s1_f7b5;
  logic [31:0] s1_imm;

  // S2: encoded word and address
  logic                  s2_valid;
  logic [31:0]           s2_instr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           count_q;
  logic                  error_q;

  logic ready_1, ready_2, advance, out_hs;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        range_err;

  assign ready_2  = !s2_valid || out_ready;
  assign ready_1  = !s1_valid || ready_2;
  // Held low through reset so nothing is accepted while the pipe is being cleared.
  assign in_ready = ready_1 && !start && reset;
  assign advance  = s1_valid && ready_2;
  assign out_hs   = s2_valid && out_ready;

  assign out_valid   = s2_valid;
  assign out_instr   = s2_instr;
  assign out_addr    = addr_q;
  assign instr_count = count_q;
  assign error       = error_q;

  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    case (s1_kind)
      4'd0: enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, OP_LOAD};
      4'd1: enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], OP_STORE};
      4'd2: enc_word = {1'b0, s1_f7b5, 5'b00000, s1_rs2, s1_rs1, s1_funct3, s1_rd, OP_REG};
      4'd3: enc_word = {s1_imm[31:12], s1_rd, OP_AUIPC};
      4'd4: enc_word = {s1_imm[31:12], s1_rd, OP_LUI};
      4'd5: enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                        s1_imm[4:1], s1_imm[11], OP_BRANCH};
      4'd6: begin
        // Shifts carry shamt in imm[4:0]; bit 30 selects SRAI over SRLI.
        if (s1_funct3 == 3'b101)
          enc_word = {1'b0, s1_f7b5, 5'b00000, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, OP_IMM};
        else if (s1_funct3 == 3'b001)
          enc_word = {7'b0000000, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, OP_IMM};
        else
          enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, OP_IMM};
      end
      4'd7: enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, OP_JAL};
      default: begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b1;
      end
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // A value fits an N-bit signed field when all bits above the field's sign
  // bit equal that sign bit.
  always_comb begin
    range_err = 1'b0;
    case (s1_kind)
      4'd0, 4'd1: range_err = (s1_imm[31:11] != {21{s1_imm[11]}});
      4'd6: begin
        if (s1_funct3 == 3'b001 || s1_funct3 == 3'b101)
          range_err = (s1_imm[31:5] != 27'd0);
        else
          range_err = (s1_imm[31:11] != {21{s1_imm[11]}});
      end
      4'd5: range_err = (s1_imm[31:12] != {20{s1_imm[12]}}) || s1_imm[0];
      4'd7: range_err = (s1_imm[31:20] != {12{s1_imm[20]}}) || s1_imm[0];
      4'd3, 4'd4: range_err = (s1_imm[11:0] != 12'd0);
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_kind   <= 4'd0;
      s1_rd     <= 5'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_funct3 <= 3'd0;
      s1_f7b5   <= 1'b0;
      s1_imm    <= 32'd0;
    end else if (start) begin
      s1_valid <= 1'b0;
    end else begin
      if (ready_1)
        s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_kind   <= kind;
        s1_rd     <= rd;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_funct3 <= funct3;
        s1_f7b5   <= funct7_b5;
        s1_imm    <= imm;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_instr <= 32'd0;
      addr_q   <= BASE;
      count_q  <= 16'd0;
      error_q  <= 1'b0;
    end else if (start) begin
      // In-flight words are dropped without being counted.
      s2_valid <= 1'b0;
      addr_q   <= BASE;
      count_q  <= 16'd0;
      error_q  <= 1'b0;
    end else begin
      if (ready_2)
        s2_valid <= s1_valid;
      if (advance) begin
        s2_instr <= enc_word;
        if (enc_illegal || range_err)
          error_q <= 1'b1;
      end
      if (out_hs) begin
        addr_q <= addr_q + ADDR_WIDTH'(4);
        if (count_q != 16'hFFFF)
          count_q <= count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder

module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [3:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm;
  logic        in_ready, out_valid, error;
  logic [31:0] out_instr, out_addr;
  logic [15:0] instr_count;

  logic        in_ready8, out_valid8, error8;
  logic [31:0] out_instr8;
  logic [7:0]  out_addr8;
  logic [15:0] instr_count8;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_words [64];
  int wr_idx = 0;
  int rd_idx = 0;
  logic [31:0] exp_addr = 32'h0;

  always #5 clock = ~clock;

  instruction_encoder dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7_b5(funct7_b5), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .instr_count(instr_count), .error(error)
  );

  // Narrow-address copy fed with the same stream, used for the wrap case.
  instruction_encoder #(.BASE_ADDR(32'h0000_00FC), .ADDR_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready8),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7_b5(funct7_b5), .imm(imm),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_instr(out_instr8), .out_addr(out_addr8),
    .instr_count(instr_count8), .error(error8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard on the output side: words must come out in acceptance order
  // at consecutive addresses.
  always @(negedge clock) begin
    if (!reset || start) begin
      rd_idx   = wr_idx;
      exp_addr = 32'h0;
    end else if (out_valid && out_ready) begin
      if (rd_idx == wr_idx) begin
        check("unexpected_word", out_instr, 32'hxxxx_xxxx);
      end else begin
        check("out_instr", out_instr, exp_words[rd_idx % 64]);
        check("out_addr", out_addr, exp_addr);
        check("out_addr8", {24'd0, out_addr8}, {24'd0, exp_addr[7:0] + 8'hFC});
        rd_idx++;
      end
      exp_addr = exp_addr + 32'd4;
    end
  end

  task automatic drive(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                       input logic [31:0] im);
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7_b5 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                      input logic [31:0] im, input logic [31:0] exp);
    bit done = 0;
    drive(k, d, s1, s2, f3, f7, im);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (in_ready) begin
        exp_words[wr_idx % 64] = exp;
        wr_idx++;
        done = 1;
      end
      @(posedge clock); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (rd_idx != wr_idx && c < 50) begin
      @(posedge clock); #1;
      c++;
    end
    check("drain", rd_idx, wr_idx);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  logic [31:0] bp_exp [4];
  logic [3:0]  bp_kind [4];
  logic [31:0] bp_imm [4];
  int acc;

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    kind = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0;
    funct7_b5 = 1'b0; imm = 32'd0;

    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_count", instr_count, 0);
    check("rst_error", error, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clock); #1;

    // Latency: accepted at edge N, visible after edge N+1.
    send(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'h00500093);
    @(negedge clock);
    check("lat_s1_not_visible", out_valid, 0);
    @(negedge clock);
    check("lat_valid", out_valid, 1);
    check("lat_instr", out_instr, 32'h00500093);
    check("lat_addr", out_addr, 32'h0);
    @(posedge clock); #1;

    send(4'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 32'h402081B3);
    send(4'd1, 5'd0, 5'd2, 5'd3, 3'd2, 1'b0, 32'd8, 32'h00312423);
    drain();
    check("count_3", instr_count, 3);

    send(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE208EE3);
    send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,      32'h001000EF);
    send(4'd0, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'hFFFF_FFF8, 32'hFF812283);
    send(4'd4, 5'd10, 5'd7, 5'd9, 3'd3, 1'b0, 32'h1234_5000, 32'h12345537);
    send(4'd6, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd3,         32'h4030D093);
    send(4'd3, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_F000, 32'hFFFFF117);
    drain();
    check("count_9", instr_count, 9);
    check("no_error_legal", error, 0);

    // Backpressure: sink stalled for 5 cycles while 4 descriptors are offered.
    bp_kind[0] = 4'd6; bp_imm[0] = 32'd1; bp_exp[0] = 32'h00100093;
    bp_kind[1] = 4'd6; bp_imm[1] = 32'd2; bp_exp[1] = 32'h00200093;
    bp_kind[2] = 4'd6; bp_imm[2] = 32'd3; bp_exp[2] = 32'h00300093;
    bp_kind[3] = 4'd6; bp_imm[3] = 32'd4; bp_exp[3] = 32'h00400093;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(bp_kind[acc], 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, bp_imm[acc]);
      @(negedge clock);
      if (c >= 2) check("bp_stable", out_instr, bp_exp[0]);
      if (in_ready) begin
        exp_words[wr_idx % 64] = bp_exp[acc];
        wr_idx++;
        acc++;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 2);
    out_ready = 1'b1;
    send(bp_kind[2], 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, bp_imm[2], bp_exp[2]);
    send(bp_kind[3], 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, bp_imm[3], bp_exp[3]);
    drain();
    check("count_13", instr_count, 13);

    // Illegal kind: NOP emitted, sticky error.
    send(4'd9, 5'd7, 5'd7, 5'd7, 3'd7, 1'b1, 32'hFFFF_FFFF, 32'h00000013);
    drain();
    repeat (3) @(posedge clock);
    #1;
    check("error_sticky", error, 1);
    pulse_start();
    check("start_error", error, 0);
    check("start_addr", out_addr, 32'h0);
    check("start_count", instr_count, 0);
    check("start_addr8", {24'd0, out_addr8}, 32'h0000_00FC);

    // Out-of-range immediate: field truncated either way.
    send(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096, 32'h00000093);
    drain();
`ifdef ENCODER_RANGE_CHECK_EN
    check("range_error", error, 1);
`else
    check("range_error", error, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
